// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: control inputs from the pipeline, the instruction memory
// read port, and the byte stream presented to the instruction register.
interface fetch_stage_if #(
   parameter int ADDR_W = 8
);
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [7:0]        imem_rdata;
   logic [7:0]        ir_new;
   logic              sf1_out;
   logic              ir_ld;
   logic [ADDR_W-1:0] ir_pc;

   modport master (
      input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
      output imem_req, imem_addr, ir_new, sf1_out, ir_ld, ir_pc
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_ack, imem_rdata,
      input  imem_req, imem_addr, ir_new, sf1_out, ir_ld, ir_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding byte reads into a small prefetch
// FIFO feeding the IR, with two-byte-instruction operand tagging and redirect.
module fetch_stage #(
   parameter int                ADDR_W      = 8,
   parameter int                DEPTH       = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]        TWO_BYTE_OP = 4'hC
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_DROP} req_state_t;

   req_state_t        state, state_next;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [7:0]        fifo_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              sf_state;
   logic              nonempty, has_room, issue, push, pop;

   assign nonempty = (count != '0);
   assign has_room = (count < CNT_W'(DEPTH));
   assign pop      = nonempty && !bus.stall && !bus.redirect;
   assign push     = (state == REQ_WAIT) && bus.imem_ack && !bus.redirect;
   assign issue    = (state == REQ_IDLE) && has_room && !bus.redirect;

   // REQ_DROP keeps the stale request alive until memory answers, then discards it.
   always_comb begin
      state_next = state;
      case (state)
         REQ_IDLE: if (issue) state_next = REQ_WAIT;
         REQ_WAIT: begin
            if (bus.imem_ack)      state_next = REQ_IDLE;
            else if (bus.redirect) state_next = REQ_DROP;
         end
         REQ_DROP: if (bus.imem_ack) state_next = REQ_IDLE;
         default:  state_next = REQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= REQ_IDLE;
         req_addr <= RESET_PC;
      end else begin
         state <= state_next;
         if (issue) req_addr <= fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         sf_state <= 1'b0;
      end else if (bus.redirect) begin
         fetch_pc <= bus.redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         sf_state <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            fetch_pc <= fetch_pc + ADDR_W'(1);
         end
         // An operand byte always returns to opcode decoding, whatever its value.
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            sf_state <= !sf_state && (fifo_data[rd_ptr][7:4] == TWO_BYTE_OP);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= fetch_pc;
         fifo_data[wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req  = (state != REQ_IDLE);
   assign bus.imem_addr = req_addr;
   assign bus.ir_ld     = pop;
   assign bus.ir_new    = nonempty ? fifo_data[rd_ptr] : 8'h00;
   assign bus.ir_pc     = nonempty ? fifo_addr[rd_ptr] : '0;
   assign bus.sf1_out   = sf_state;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the fetched byte stream.
module tb_fetch_stage;
   localparam int         ADDR_W      = 8;
   localparam int         DEPTH       = 4;
   localparam logic [7:0] RESET_PC    = 8'h00;
   localparam logic [3:0] TWO_BYTE_OP = 4'hC;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;

   fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_stage #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .TWO_BYTE_OP(TWO_BYTE_OP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mem [256];
   ent_t       q [$];
   logic [7:0] m_pc, m_addr;
   logic       m_req, m_drop, m_sf;
   int         lat        = 1;
   int         mem_wait   = 0;
   int         dut_issues = 0;
   int         ld_seen    = 0;
   logic       prev_req   = 1'b0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc     = RESET_PC;
      m_addr   = RESET_PC;
      m_req    = 1'b0;
      m_drop   = 1'b0;
      m_sf     = 1'b0;
      mem_wait = 0;
      prev_req = 1'b0;
   endtask

   task automatic do_reset();
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 8'h00;
      rst = 1'b0;
      #1;
      check_output("rst_imem_req", 32'(bus.imem_req), 0);
      check_output("rst_ir_ld", 32'(bus.ir_ld), 0);
      check_output("rst_ir_new", 32'(bus.ir_new), 0);
      check_output("rst_ir_pc", 32'(bus.ir_pc), 0);
      check_output("rst_sf1_out", 32'(bus.sf1_out), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   // One clock cycle: memory responds, inputs are driven, outputs are checked
   // against the model, then the model advances across the rising edge.
   task automatic apply_stimulus(input logic st, input logic rd, input logic [7:0] rpc,
                                 input logic force_ack);
      logic ack_v;
      logic exp_ld;
      logic nxt_req;
      ent_t e;
      if (bus.imem_req && !prev_req) dut_issues++;
      prev_req = bus.imem_req;
      ack_v = force_ack;
      if (bus.imem_req) begin
         mem_wait++;
         if (mem_wait >= lat) ack_v = 1'b1;
      end else begin
         mem_wait = 0;
      end
      if (ack_v) mem_wait = 0;
      bus.stall       = st;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_ack    = ack_v;
      bus.imem_rdata  = ack_v ? mem[bus.imem_addr] : 8'h00;
      #1;
      exp_ld = (q.size() != 0) && !st && !rd;
      check_output("imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) check_output("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
      check_output("ir_ld", 32'(bus.ir_ld), 32'(exp_ld));
      check_output("sf1_out", 32'(bus.sf1_out), 32'(m_sf));
      if (q.size() != 0) begin
         check_output("ir_pc", 32'(bus.ir_pc), 32'(q[0].addr));
         check_output("ir_new", 32'(bus.ir_new), 32'(q[0].data));
      end else begin
         check_output("ir_pc_empty", 32'(bus.ir_pc), 0);
         check_output("ir_new_empty", 32'(bus.ir_new), 0);
      end
      if (bus.ir_ld) ld_seen++;

      nxt_req = m_req ? !ack_v : (!rd && q.size() < DEPTH);
      if (!m_req && nxt_req) m_addr = m_pc;
      if (exp_ld) begin
         e    = q.pop_front();
         m_sf = !m_sf && (e.data[7:4] == TWO_BYTE_OP);
      end
      if (m_req && ack_v && !m_drop && !rd) begin
         e.addr = m_pc;
         e.data = mem[m_pc];
         q.push_back(e);
         m_pc = m_pc + 8'd1;
      end
      if (m_req && ack_v)    m_drop = 1'b0;
      else if (m_req && rd)  m_drop = 1'b1;
      if (rd) begin
         q.delete();
         m_sf = 1'b0;
         m_pc = rpc;
      end
      m_req = nxt_req;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int   base;
      logic found;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h00] = 8'h10;
      mem[8'h01] = 8'h20;
      mem[8'h02] = 8'h30;
      mem[8'h80] = 8'hC5;
      mem[8'h81] = 8'hC7;
      mem[8'h82] = 8'h11;
      rst             = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 8'h00;
      @(negedge clk);
      do_reset();

      $display("[TB] sequential fetch from reset");
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] stall fills credit");
      do_reset();
      base = dut_issues;
      for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      check_output("stall_issues", 32'(dut_issues - base), 4);
      check_output("stall_req_low", 32'(bus.imem_req), 0);
      base = ld_seen;
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check_output("stall_release_lds", 32'(ld_seen - base), 4);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] two-byte opcode tagging");
      apply_stimulus(1'b0, 1'b1, 8'h80, 1'b0);
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] redirect during slow outstanding read");
      lat = 3;
      apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.imem_req && bus.imem_addr == 8'h02) found = 1'b1;
         else apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      end
      check_output("find_req_addr2", 32'(found), 1);
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(1'b0, 1'b1, 8'h40, 1'b0);
      for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] address wrap");
      lat = 1;
      apply_stimulus(1'b0, 1'b1, 8'hFE, 1'b0);
      for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] reset mid-operation");
      lat = 3;
      apply_stimulus(1'b1, 1'b1, 8'h50, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (q.size() == 3 && m_req) found = 1'b1;
         else apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      end
      check_output("find_count3_pending", 32'(found), 1);
      lat = 1;
      do_reset();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
      check_output("post_rst_req", 32'(bus.imem_req), 1);
      check_output("post_rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) lat = int'($urandom_range(1, 4));
         apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                        8'($urandom), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
